// File: rtl/fpu_table_pkg.sv
// Shared types and helpers for the FPU seed-table loader.
`default_nettype none

package fpu_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } table_writer_state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into DATA_WIDTH-bit words; word_o already includes the byte on the input.
`default_nettype none

module byte_packer
  import fpu_table_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] c_LAST_LANE = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] word_q;

  always_comb begin
    word_o = word_q;
    word_o[int'(idx_q) * 8 +: 8] = byte_i;
    word_valid_o = byte_valid_i && (idx_q == c_LAST_LANE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (byte_valid_i) begin
      word_q <= word_o;
      idx_q  <= (idx_q == c_LAST_LANE) ? '0 : idx_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/table_writer.sv
// Streams bytes into a lookup-table RAM write port, one registered write per packed word.
`default_nettype none

module table_writer
  import fpu_table_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  if ((DATA_WIDTH % 8 != 0) || (DATA_DEPTH > (1 << ADDR_WIDTH))) begin : g_param_check
    $error("table_writer: DATA_WIDTH must be a multiple of 8 and DATA_DEPTH must fit in ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH:0] c_LAST_WORD = (ADDR_WIDTH + 1)'(DATA_DEPTH - 1);

  table_writer_state_t state_q, state_d;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] checksum_q;

  logic                  start_ok;
  logic                  byte_ok;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;

  assign in_ready_o = (state_q == LOAD);
  assign busy_o     = (state_q == LOAD);
  assign done_o     = (state_q == DONE);
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign count_o    = count_q;
  assign checksum_o = checksum_q;

  // abort wins over both a start and a byte handshake in the same cycle
  assign start_ok = start_i && !abort_i && (state_q != LOAD);
  assign byte_ok  = in_valid_i && in_ready_o && !abort_i;

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_ok || abort_i),
    .byte_valid_i (byte_ok),
    .byte_i       (in_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (abort_i)      state_d = IDLE;
        else if (start_i) state_d = LOAD;
      end
      LOAD: begin
        if (abort_i)                                  state_d = IDLE;
        else if (word_valid && count_q == c_LAST_WORD) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      checksum_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      if (start_ok) begin
        count_q    <= '0;
        checksum_q <= '0;
      end else if (word_valid) begin
        we_q       <= 1'b1;
        waddr_q    <= count_q[ADDR_WIDTH-1:0];
        wdata_q    <= word;
        count_q    <= count_q + 1'b1;
        checksum_q <= checksum_q + word;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_table_writer.sv
// Directed/randomized bench for table_writer against a byte-level reference model and behavioural RAM.
`default_nettype none

module tb_table_writer;

  localparam int DW = 32;
  localparam int DD = 4;
  localparam int AW = 2;
  localparam int NB = DD * (DW / 8);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, abort_i, in_valid_i;
  logic [7:0]    in_data_i;
  logic          in_ready_o, we_o, busy_o, done_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o, checksum_o;
  logic [AW:0]   count_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [DD];
  int            we_count = 0;
  logic [7:0]    bytes [NB];
  logic [DW-1:0] exp_sum;

  table_writer #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .count_o    (count_o),
    .checksum_o (checksum_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we_o === 1'b1) begin
      ram[waddr_o] = wdata_o;
      we_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mword(input int j);
    return {bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]};
  endfunction

  task automatic clear_ram();
    for (int j = 0; j < DD; j++) ram[j] = 'x;
    we_count = 0;
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    exp_sum = '0;
    chk("start_busy", busy_o, 1);
    chk("start_ready", in_ready_o, 1);
    chk("start_count", count_o, 0);
    chk("start_sum", checksum_o, 0);
  endtask

  task automatic load_bytes(input int n, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid_i = 1'b0;
          in_data_i  = 8'($urandom);
          step();
          chk("gap_we", we_o, 0);
        end
      end
      in_valid_i = 1'b1;
      in_data_i  = bytes[i];
      guard = 0;
      while (in_ready_o !== 1'b1 && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) chk("ready_timeout", in_ready_o, 1);
      step();
      in_valid_i = 1'b0;
      chk("byte_we", we_o, (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 3) begin
        exp_sum = exp_sum + mword(i / 4);
        chk("word_addr", waddr_o, i / 4);
        chk("word_data", wdata_o, mword(i / 4));
        chk("word_count", count_o, i / 4 + 1);
        chk("word_sum", checksum_o, exp_sum);
      end
      chk("done_flag", done_o, (i == NB - 1) ? 1 : 0);
    end
  endtask

  task automatic check_ram();
    step();
    for (int j = 0; j < DD; j++) chk("ram_word", ram[j], mword(j));
    chk("we_pulses", we_count, DD);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b1; in_data_i = 8'h55;
    clear_ram();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_ready", in_ready_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_waddr", waddr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_sum", checksum_o, 0);
    repeat (3) begin
      step();
      chk("idle_ready", in_ready_o, 0);
    end
    chk("idle_no_we", we_count, 0);
    in_valid_i = 1'b0;

    // Back-to-back load of 01..10
    for (int i = 0; i < NB; i++) bytes[i] = 8'(i + 1);
    do_start();
    load_bytes(NB, 1'b0);
    chk("last_we", we_o, 1);
    chk("last_ready", in_ready_o, 0);
    check_ram();
    chk("hold_done", done_o, 1);
    chk("hold_ready", in_ready_o, 0);

    // Same bytes with random valid gaps, started from DONE
    clear_ram();
    do_start();
    load_bytes(NB, 1'b1);
    check_ram();

    // Random data with random gaps
    for (int r = 0; r < 3; r++) begin
      clear_ram();
      rand_bytes();
      do_start();
      load_bytes(NB, 1'b1);
      check_ram();
    end

    // Abort after 6 bytes, with a byte offered in the abort cycle
    clear_ram();
    rand_bytes();
    do_start();
    load_bytes(6, 1'b0);
    abort_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'hA5;
    step();
    abort_i = 1'b0; in_valid_i = 1'b0;
    chk("abort_we", we_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_ready", in_ready_o, 0);
    chk("abort_count", count_o, 1);
    chk("abort_sum", checksum_o, mword(0));
    step();
    chk("abort_writes", we_count, 1);
    chk("abort_ram0", ram[0], mword(0));
    clear_ram();
    rand_bytes();
    do_start();
    load_bytes(NB, 1'b0);
    chk("reload_count", count_o, DD);
    check_ram();

    // Reset coinciding with the final byte
    clear_ram();
    rand_bytes();
    do_start();
    load_bytes(NB - 1, 1'b0);
    in_valid_i = 1'b1; in_data_i = bytes[NB-1];
    rst = 1'b1;
    #1;
    chk("arst_ready", in_ready_o, 0);
    chk("arst_count", count_o, 0);
    step();
    in_valid_i = 1'b0;
    chk("arst_we", we_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_waddr", waddr_o, 0);
    chk("arst_wdata", wdata_o, 0);
    chk("arst_sum", checksum_o, 0);
    rst = 1'b0;
    step();
    chk("arst_writes", we_count, DD - 1);
    chk("arst_idle_done", done_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
